shared_resource_arbiter: RTL and testbench

//  Initiator side of the shared-resource interface. Arbitrates two pipeline lanes

---
 rtl/shared_resource_arbiter.sv | 125 ++++++++++++
 tb/tb_shared_resource_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/shared_resource_arbiter.sv
// Two-lane initiator for a shared 1-cycle-latency resource: round-robin issue, tagged response routing.
// Optional per-lane saturating stall counters are enabled with `define SRA_STALL_CNT_EN.
module shared_resource_arbiter #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          req_valid,
    input  logic [2*DATA_W-1:0] req_data,
    output logic [1:0]          req_ready,
    output logic [1:0]          rsp_valid,
    output logic [2*DATA_W-1:0] rsp_data,
    input  logic [1:0]          rsp_ready,
    output logic [1:0]          res_in_valid,
    output logic [DATA_W-1:0]   res_in_data,
    input  logic [1:0]          res_out_valid,
    input  logic [DATA_W-1:0]   res_out_data,
    output logic                stall,
`ifdef SRA_STALL_CNT_EN
    output logic [CNT_W-1:0]    stall_cnt0,
    output logic [CNT_W-1:0]    stall_cnt1,
`endif
    output logic                err_unexp
);

    logic [1:0]          busy_q, busy_d;
    logic                rr_ptr_q, rr_ptr_d;
    logic [1:0]          res_in_valid_q, res_in_valid_d;
    logic [DATA_W-1:0]   res_in_data_q, res_in_data_d;
    logic [1:0]          rsp_valid_q, rsp_valid_d;
    logic [2*DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic                err_q, err_d;

    logic [1:0] eligible, grant, release_l, capture, tag_onehot;

    always_comb begin
        eligible = req_valid & ~busy_q;
        // Contention goes to rr_ptr; a lone eligible lane always wins.
        if (eligible == 2'b11) grant = rr_ptr_q ? 2'b10 : 2'b01;
        else                   grant = eligible;
    end

    always_comb begin
        rr_ptr_d       = rr_ptr_q;
        res_in_data_d  = res_in_data_q;
        res_in_valid_d = grant;
        if (|grant) begin
            rr_ptr_d      = ~grant[1];
            res_in_data_d = grant[1] ? req_data[DATA_W +: DATA_W] : req_data[0 +: DATA_W];
        end

        release_l  = rsp_valid_q & rsp_ready;
        busy_d     = (busy_q & ~release_l) | grant;

        // Only a well-formed tag for a lane that is waiting with an empty buffer is accepted.
        tag_onehot = (res_out_valid == 2'b01 || res_out_valid == 2'b10) ? res_out_valid : 2'b00;
        capture    = tag_onehot & busy_q & ~rsp_valid_q;

        rsp_valid_d = (rsp_valid_q & ~release_l) | capture;
        rsp_data_d  = rsp_data_q;
        for (int i = 0; i < 2; i++) begin
            if (capture[i]) rsp_data_d[i*DATA_W +: DATA_W] = res_out_data;
        end
        err_d = err_q | ((|res_out_valid) & ~(|capture));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q         <= '0;
            rr_ptr_q       <= 1'b0;
            res_in_valid_q <= '0;
            res_in_data_q  <= '0;
            rsp_valid_q    <= '0;
            rsp_data_q     <= '0;
            err_q          <= 1'b0;
        end else begin
            busy_q         <= busy_d;
            rr_ptr_q       <= rr_ptr_d;
            res_in_valid_q <= res_in_valid_d;
            res_in_data_q  <= res_in_data_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_data_q     <= rsp_data_d;
            err_q          <= err_d;
        end
    end

    assign req_ready    = grant;
    assign stall        = |(req_valid & ~grant);
    assign rsp_valid    = rsp_valid_q;
    assign rsp_data     = rsp_data_q;
    assign res_in_valid = res_in_valid_q;
    assign res_in_data  = res_in_data_q;
    assign err_unexp    = err_q;

`ifdef SRA_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt0_q, stall_cnt0_d, stall_cnt1_q, stall_cnt1_d;
    logic [1:0]       lane_stall;

    always_comb begin
        lane_stall   = req_valid & ~grant;
        stall_cnt0_d = stall_cnt0_q;
        stall_cnt1_d = stall_cnt1_q;
        if (lane_stall[0] && stall_cnt0_q != '1) stall_cnt0_d = stall_cnt0_q + 1'b1;
        if (lane_stall[1] && stall_cnt1_q != '1) stall_cnt1_d = stall_cnt1_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt0_q <= '0;
            stall_cnt1_q <= '0;
        end else begin
            stall_cnt0_q <= stall_cnt0_d;
            stall_cnt1_q <= stall_cnt1_d;
        end
    end

    assign stall_cnt0 = stall_cnt0_q;
    assign stall_cnt1 = stall_cnt1_q;
`else
    logic [CNT_W-1:0] unused_cnt_w;
    assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_shared_resource_arbiter.sv
// Bench for shared_resource_arbiter: doubling resource model, per-lane result scoreboard, scenario tasks.
module tb_shared_resource_arbiter;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    req_valid, req_ready, rsp_valid, rsp_ready, res_in_valid, res_out_valid;
    logic [2*DW-1:0] req_data, rsp_data;
    logic [DW-1:0] res_in_data, res_out_data;
    logic          stall, err_unexp;
`ifdef SRA_STALL_CNT_EN
    logic [15:0]   stall_cnt0, stall_cnt1;
`endif

    logic [1:0]    mdl_valid = 2'b00;
    logic [DW-1:0] mdl_data  = '0;
    logic          inj_en = 1'b0;
    logic [1:0]    inj_valid = 2'b00;
    logic [DW-1:0] inj_data = '0;
    logic          sb_en = 1'b0;
    logic [DW-1:0] sb_q0[$], sb_q1[$];
    int            n_assert = 0, n_fail = 0;

    always #5 clk = ~clk;

    // Resource model: one cycle of latency, result is the operand doubled.
    always @(posedge clk) begin
        mdl_valid <= res_in_valid;
        mdl_data  <= res_in_data << 1;
    end
    assign res_out_valid = inj_en ? inj_valid : mdl_valid;
    assign res_out_data  = inj_en ? inj_data  : mdl_data;

    shared_resource_arbiter #(.DATA_W(DW), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
        .res_in_valid(res_in_valid), .res_in_data(res_in_data),
        .res_out_valid(res_out_valid), .res_out_data(res_out_data),
        .stall(stall),
`ifdef SRA_STALL_CNT_EN
        .stall_cnt0(stall_cnt0), .stall_cnt1(stall_cnt1),
`endif
        .err_unexp(err_unexp)
    );

    task automatic sample();
        @(negedge clk);
    endtask

    // Called at the sampling point: scoreboard push on accept, pop on consume, then next cycle.
    task automatic advance();
        logic [DW-1:0] exp;
        if (sb_en) begin
            if (req_ready[0]) sb_q0.push_back(req_data[0 +: DW] << 1);
            if (req_ready[1]) sb_q1.push_back(req_data[DW +: DW] << 1);
            if (rsp_valid[0] && rsp_ready[0]) begin
                n_assert++;
                if (sb_q0.size() == 0) begin
                    n_fail++; $display("FAIL sb_lane0: got result %0d, expected none", rsp_data[0 +: DW]);
                end else begin
                    exp = sb_q0.pop_front();
                    if (rsp_data[0 +: DW] !== exp) begin
                        n_fail++; $display("FAIL sb_lane0: got %0d, expected %0d", rsp_data[0 +: DW], exp);
                    end
                end
            end
            if (rsp_valid[1] && rsp_ready[1]) begin
                n_assert++;
                if (sb_q1.size() == 0) begin
                    n_fail++; $display("FAIL sb_lane1: got result %0d, expected none", rsp_data[DW +: DW]);
                end else begin
                    exp = sb_q1.pop_front();
                    if (rsp_data[DW +: DW] !== exp) begin
                        n_fail++; $display("FAIL sb_lane1: got %0d, expected %0d", rsp_data[DW +: DW], exp);
                    end
                end
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; req_valid = 2'b00; req_data = '0; rsp_ready = 2'b11; inj_en = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        sb_q0.delete(); sb_q1.delete();
    endtask

    task automatic drain(input int n);
        req_valid = 2'b00; rsp_ready = 2'b11;
        repeat (n) begin sample(); advance(); end
    endtask

    task automatic test_reset();
        do_reset();
        sample();
        n_assert++; if (res_in_valid !== 2'b00) begin n_fail++; $display("FAIL reset_res_in_valid: got %b, expected 00", res_in_valid); end
        n_assert++; if (res_in_data !== '0) begin n_fail++; $display("FAIL reset_res_in_data: got %h, expected 0", res_in_data); end
        n_assert++; if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL reset_rsp_valid: got %b, expected 00", rsp_valid); end
        n_assert++; if (rsp_data !== '0) begin n_fail++; $display("FAIL reset_rsp_data: got %h, expected 0", rsp_data); end
        n_assert++; if (err_unexp !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b, expected 0", err_unexp); end
        n_assert++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b, expected 0", stall); end
        advance();
    endtask

    task automatic test_single_latency();
        sb_en = 1'b1;
        req_valid = 2'b01; req_data = {32'd0, 32'd5};
        sample();
        n_assert++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL t1_ready: got %b, expected 01", req_ready); end
        n_assert++; if (stall !== 1'b0) begin n_fail++; $display("FAIL t1_stall: got %b, expected 0", stall); end
        advance();
        req_valid = 2'b00;
        sample();
        n_assert++; if (res_in_valid !== 2'b01 || res_in_data !== 32'd5) begin
            n_fail++; $display("FAIL t1_res_in: got %b/%0d, expected 01/5", res_in_valid, res_in_data); end
        advance();
        sample();
        n_assert++; if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL t1_early_rsp: got %b, expected 00", rsp_valid); end
        advance();
        sample();
        n_assert++; if (rsp_valid !== 2'b01 || rsp_data[0 +: DW] !== 32'd10) begin
            n_fail++; $display("FAIL t1_rsp: got %b/%0d, expected 01/10", rsp_valid, rsp_data[0 +: DW]); end
        advance();
        sample();
        n_assert++; if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL t1_consumed: got %b, expected 00", rsp_valid); end
        advance();
    endtask

    task automatic test_both_lanes();
        do_reset();
        req_valid = 2'b11; req_data = {32'd7, 32'd3};
        sample();
        n_assert++; if (req_ready !== 2'b01 || stall !== 1'b1) begin
            n_fail++; $display("FAIL t2_first_grant: got %b stall %b, expected 01 stall 1", req_ready, stall); end
        advance();
        req_valid = 2'b10;
        sample();
        n_assert++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL t2_second_grant: got %b, expected 10", req_ready); end
        advance();
        req_valid = 2'b00;
        sample(); advance();
        sample();
        n_assert++; if (rsp_valid !== 2'b01 || rsp_data[0 +: DW] !== 32'd6) begin
            n_fail++; $display("FAIL t2_rsp0: got %b/%0d, expected 01/6", rsp_valid, rsp_data[0 +: DW]); end
        advance();
        sample();
        n_assert++; if (rsp_valid !== 2'b10 || rsp_data[DW +: DW] !== 32'd14) begin
            n_fail++; $display("FAIL t2_rsp1: got %b/%0d, expected 10/14", rsp_valid, rsp_data[DW +: DW]); end
        advance();
    endtask

    task automatic test_fairness();
        int  cnt0 = 0, cnt1 = 0;
        bit  have_prev = 0;
        logic prev = 1'b0;
        req_valid = 2'b11; rsp_ready = 2'b11;
        for (int c = 0; c < 40; c++) begin
            req_data = {$urandom(), $urandom()};
            sample();
            n_assert++; if (req_ready === 2'b11) begin n_fail++; $display("FAIL t3_double_grant: got 11 at cycle %0d, expected at most one", c); end
            if (|req_ready) begin
                if (have_prev) begin
                    n_assert++;
                    if (req_ready[1] === prev) begin n_fail++; $display("FAIL t3_alternate: got lane %0d twice at cycle %0d, expected other lane", prev, c); end
                end
                prev = req_ready[1]; have_prev = 1;
                if (req_ready[1]) cnt1++; else cnt0++;
            end
            advance();
        end
        n_assert++; if (cnt0 < 8 || cnt1 < 8) begin
            n_fail++; $display("FAIL t3_starve: got grants %0d/%0d, expected >=8 each", cnt0, cnt1); end
        drain(6);
    endtask

    task automatic test_stall_hold();
        int held = 0, l1 = 0;
        req_valid = 2'b11; rsp_ready = 2'b10; req_data = {32'd4, 32'd9};
        for (int c = 0; c < 14; c++) begin
            sample();
            if (rsp_valid[0]) begin
                held++;
                n_assert++; if (rsp_data[0 +: DW] !== 32'd18 || req_ready[0] !== 1'b0 || stall !== 1'b1) begin
                    n_fail++; $display("FAIL t4_hold: got data %0d ready %b stall %b, expected 18/0/1", rsp_data[0 +: DW], req_ready[0], stall); end
            end
            if (req_ready[1]) l1++;
            advance();
        end
        n_assert++; if (held < 5) begin n_fail++; $display("FAIL t4_held_cycles: got %0d, expected >=5", held); end
        n_assert++; if (l1 < 2) begin n_fail++; $display("FAIL t4_lane1_served: got %0d grants, expected >=2", l1); end
        drain(6);
        n_assert++; if (sb_q0.size() != 0 || sb_q1.size() != 0) begin
            n_fail++; $display("FAIL sb_leftover: got %0d/%0d pending, expected 0/0", sb_q0.size(), sb_q1.size()); end
        sb_en = 1'b0;
    endtask

    task automatic test_errors();
        do_reset();
        inj_en = 1'b1; inj_valid = 2'b11; inj_data = 32'd77;
        sample();
        n_assert++; if (err_unexp !== 1'b0) begin n_fail++; $display("FAIL t5_err_pre: got %b, expected 0", err_unexp); end
        advance();
        inj_en = 1'b0;
        sample();
        n_assert++; if (err_unexp !== 1'b1 || rsp_valid !== 2'b00) begin
            n_fail++; $display("FAIL t5_err_11: got err %b rsp %b, expected 1/00", err_unexp, rsp_valid); end
        advance();
        do_reset();
        sample();
        n_assert++; if (err_unexp !== 1'b0) begin n_fail++; $display("FAIL t5_err_clear: got %b, expected 0", err_unexp); end
        advance();
        inj_en = 1'b1; inj_valid = 2'b10; inj_data = 32'd55;
        sample(); advance();
        inj_en = 1'b0;
        sample();
        n_assert++; if (err_unexp !== 1'b1 || rsp_valid !== 2'b00) begin
            n_fail++; $display("FAIL t5_err_idle: got err %b rsp %b, expected 1/00", err_unexp, rsp_valid); end
        advance();
        repeat (3) begin sample(); advance(); end
        sample();
        n_assert++; if (err_unexp !== 1'b1) begin n_fail++; $display("FAIL t5_sticky: got %b, expected 1", err_unexp); end
        advance();
    endtask

    task automatic test_reset_midflight();
        do_reset();
        req_valid = 2'b01; req_data = {32'd0, 32'd5};
        sample();
        n_assert++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL t6_grant: got %b, expected 01", req_ready); end
        advance();
        req_valid = 2'b00;
        sample(); advance();
        reset = 1'b1;
        sample(); advance();
        reset = 1'b0;
        inj_en = 1'b1; inj_valid = 2'b01; inj_data = 32'd10;
        sample();
        n_assert++; if (res_in_valid !== 2'b00 || res_in_data !== '0 || rsp_valid !== 2'b00 || rsp_data !== '0 || err_unexp !== 1'b0) begin
            n_fail++; $display("FAIL t6_cleared: got in %b/%0d rsp %b err %b, expected all 0", res_in_valid, res_in_data, rsp_valid, err_unexp); end
        advance();
        inj_en = 1'b0;
        sample();
        n_assert++; if (err_unexp !== 1'b1 || rsp_valid !== 2'b00) begin
            n_fail++; $display("FAIL t6_late: got err %b rsp %b, expected 1/00", err_unexp, rsp_valid); end
        advance();
    endtask

    initial begin
        reset = 1'b1; req_valid = 2'b00; req_data = '0; rsp_ready = 2'b11;
        test_reset();
        test_single_latency();
        test_both_lanes();
        test_fairness();
        test_stall_hold();
        test_errors();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
